uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single transmit stream of the 115200-baud UART core (to_uart_* ready/valid byte interface) between NUM_REQ byte-stream requesters.
- Arbitration is round-robin at message granularity: a grant is held until the granted requester's last byte is accepted, so messages never interleave on the wire.
- A stall timeout releases a hung requester.
- Sits between the system's message sources (status, debug, command replies) and the UART core's to_uart port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must satisfy 2**IDW >= NUM_REQ.
- TIMEOUT_CYC, 1023, consecutive stalled cycles inside a message before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low: asserted when 0.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a message; qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester byte accepted.
- to_uart_data  out  8  byte to the UART core.
- to_uart_valid  out  1  byte valid to the UART core.
- to_uart_error  out  1  tied 0.
- to_uart_ready  in  1  UART core accepts a byte.
- grant_id  out  IDW  index of the current or last granted requester.
- busy  out  1  high while a message is owned.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - state=IDLE; grant_id=0; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - busy=0, timeout_err=0, stall counter=0.
  - All req_ready=0, to_uart_valid=0, to_uart_data=0.
- Reset mid-message drops the message with no further bytes. The partial message is not resumed after reset.
- States: IDLE, (TAG), PASS.
- IDLE:
  - If any req_valid is set, register grant = first set bit searching upward from rr_ptr+1, with wrap modulo NUM_REQ.
  - Then set busy=1 and go to PASS next cycle (to TAG if the optional feature is enabled).
  - No output handshakes occur in IDLE.
- PASS: combinational pass-through of the granted requester g only.
  - to_uart_valid=req_valid[g] and to_uart_data=req_data[g].
  - req_ready[g]=to_uart_ready; all other req_ready=0.
- Transfer occurs when req_valid[g] & to_uart_ready.
  - A transfer with req_last[g]=1 moves to IDLE next cycle, with rr_ptr=g and busy=0.
- Latency: with TAG disabled, the first byte can be accepted 1 cycle after req_valid rises in IDLE.
- Minimum gap between messages: 1 IDLE cycle.
- Stall counter:
  - Increments each PASS cycle in which req_valid[g]=0.
  - Clears on any transfer and on leaving PASS.
  - Stalls caused by to_uart_ready=0 while valid is high do not count.
  - When the counter reaches TIMEOUT_CYC (TIMEOUT_CYC>0): pulse timeout_err for 1 cycle, go to IDLE, set rr_ptr=g and busy=0. Remaining bytes of that message are later sent as a new message.
- A single-byte message (valid and last together) is legal.
- A requester that drops valid mid-message keeps the grant until it resumes or the timeout fires.
- Requests arriving during PASS wait; no preemption.
- grant_id holds its value in IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Defined: after arbitration the FSM enters TAG and drives to_uart_valid=1 with to_uart_data=8'h30+g (ASCII digit).
  - Holds until to_uart_ready, then goes to PASS.
  - req_ready is all-zero in TAG.
  - The stall counter does not run in TAG.
  - First requester byte is delayed by one extra handshake.
- Not defined: the TAG state and its logic are absent; IDLE goes straight to PASS.

Test Plan:
- Single message: requester 1 sends 0x41,0x42,0x43 (last on 0x43), to_uart_ready=1 → to_uart_data sequence 41,42,43 on consecutive cycles, first 1 cycle after valid; grant_id=1; busy falls the cycle after 0x43.
- Contention: all 4 requesters hold 2-byte messages from reset → messages leave in order 0,1,2,3,0 with no interleaving and exactly 1 idle cycle between messages.
- Backpressure: to_uart_ready toggles 1,0,0,1 during requester 2's message → bytes are neither lost nor duplicated; req_ready[2] mirrors to_uart_ready; the stall counter stays 0.
- Timeout: TIMEOUT_CYC=8; requester 0 sends 1 byte without last, then drops valid → timeout_err pulses exactly 8 cycles after the byte; next the grant goes to waiting requester 3.
- Reset mid-message: assert reset during requester 2's second byte → outputs are zero immediately (asynchronously); after release the first grant goes to requester 0.
- UART_TX_ARB_TAG_EN build: requester 3 sends 0x55 (last) → wire sequence 0x33,0x55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Message-granular round-robin arbiter sharing one UART transmit byte stream.
// Define UART_TX_ARB_TAG_EN to prefix each message with an ASCII requester digit.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           to_uart_data,
  output logic                 to_uart_valid,
  output logic                 to_uart_error,
  input  logic                 to_uart_ready,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PASS = 2'd1, S_TAG = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_PASS = 1'b1} state_t;
`endif

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic           busy_q, busy_d;
  logic           tmo_q, tmo_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [7:0]     lane [NUM_REQ];
  logic [IDW-1:0] pick, pick_hi, pick_lo;
  logic           found_hi;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = req_data[8*i +: 8];
  end

  // Round-robin pick: lowest valid index above rr_q, else lowest valid index overall.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) > rr_q)) begin
        pick_hi  = IDW'(i);
        found_hi = 1'b1;
      end
      if (req_valid[i]) begin
        pick_lo = IDW'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    busy_d        = busy_q;
    tmo_d         = 1'b0;
    cnt_d         = cnt_q;
    to_uart_valid = 1'b0;
    to_uart_data  = '0;
    req_ready     = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|req_valid) begin
          grant_d = pick;
          busy_d  = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_PASS;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      S_TAG: begin
        cnt_d         = '0;
        to_uart_valid = 1'b1;
        to_uart_data  = 8'h30 + 8'(grant_q);
        if (to_uart_ready) begin
          state_d = S_PASS;
        end
      end
`endif
      S_PASS: begin
        to_uart_valid      = req_valid[grant_q];
        to_uart_data       = lane[grant_q];
        req_ready[grant_q] = to_uart_ready;
        if (req_valid[grant_q] && to_uart_ready) begin
          cnt_d = '0;
          if (req_last[grant_q]) begin
            state_d = S_IDLE;
            rr_d    = grant_q;
            busy_d  = 1'b0;
          end
        end else if (!req_valid[grant_q] && (TIMEOUT_CYC != 0)) begin
          // Only source-side stalls count; UART backpressure never times out.
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT_CYC)) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
            rr_d    = grant_q;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= IDW'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout_err   = tmo_q;
  assign to_uart_error = 1'b0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: vector table, directed corner sequences, and random
// message streams checked against a queue-based round-robin message-order model.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [7:0]    to_uart_data;
  logic          to_uart_valid;
  logic          to_uart_error;
  logic          to_uart_ready;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDW(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .to_uart_data(to_uart_data), .to_uart_valid(to_uart_valid), .to_uart_error(to_uart_error),
    .to_uart_ready(to_uart_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; to_uart_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] v;  int src; logic [7:0] d; logic l; logic rdy;
    logic ev; logic [7:0] ed; logic [3:0] er; logic eb; logic [1:0] eg;
  } vec_t;

  // Stream model state
  logic [7:0] bq [NR][$];
  bit         lq [NR][$];
  int         mlen [NR][$];
  int         mc [NR];
  int         exp_src [$];
  logic [7:0] exp_byte [$];
  bit         exp_first [$];
  bit         exp_last [$];

  // Builds per-requester messages and the expected wire order: each new message
  // comes from the next requester after the previous owner that still has messages.
  task automatic build_model(input int fixlen, input int maxlen);
    int rem [NR];
    int off [NR];
    int p, c, len;
    bit any;
    exp_src.delete(); exp_byte.delete(); exp_first.delete(); exp_last.delete();
    for (int i = 0; i < NR; i++) begin
      bq[i].delete(); lq[i].delete(); mlen[i].delete();
      for (int m = 0; m < mc[i]; m++) begin
        len = (fixlen > 0) ? fixlen : int'($urandom_range(1, maxlen));
        mlen[i].push_back(len);
        for (int b = 0; b < len; b++) begin
          bq[i].push_back(8'($urandom));
          lq[i].push_back(b == len - 1);
        end
      end
      rem[i] = mc[i];
      off[i] = 0;
    end
    p = NR - 1;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      c = -1;
      for (int k = 1; k <= NR; k++) begin
        if (c < 0 && rem[(p + k) % NR] > 0) c = (p + k) % NR;
      end
      if (c >= 0) begin
        any = 1'b1;
        len = mlen[c][mc[c] - rem[c]];
        for (int b = 0; b < len; b++) begin
          exp_src.push_back(c);
          exp_byte.push_back(bq[c][off[c] + b]);
          exp_first.push_back(b == 0);
          exp_last.push_back(b == len - 1);
        end
        off[c] += len;
        rem[c]--;
        p = c;
      end
    end
  endtask

  task automatic run_stream(input bit full, input bit gaps_on, input string tag);
    int gap [NR];
    int cyc = 0;
    int last_cyc = -1;
    int hs;
    bit tmo_seen = 1'b0;
    bit lst;
    for (int i = 0; i < NR; i++) gap[i] = 0;
    while (exp_byte.size() > 0 && cyc < 4000) begin
      for (int i = 0; i < NR; i++) begin
        if (bq[i].size() > 0 && gap[i] == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = bq[i][0];
          req_last[i] = lq[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
      to_uart_ready = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tmo_seen |= timeout_err;
      hs = -1;
      for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) hs = i;
      if (to_uart_valid && to_uart_ready) begin
        check({tag, "_src"}, 32'(hs), 32'(exp_src[0]));
        check({tag, "_byte"}, {24'h0, to_uart_data}, {24'h0, exp_byte[0]});
        if (full && exp_first[0] && last_cyc >= 0)
          check({tag, "_gap"}, 32'(cyc - last_cyc), 32'd2);
        if (exp_last[0]) last_cyc = cyc;
        void'(exp_src.pop_front()); void'(exp_byte.pop_front());
        void'(exp_first.pop_front()); void'(exp_last.pop_front());
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (gap[i] > 0) gap[i]--;
      if (hs >= 0) begin
        lst = lq[hs][0];
        void'(bq[hs].pop_front()); void'(lq[hs].pop_front());
        if (!lst && gaps_on && $urandom_range(0, 2) == 0) gap[hs] = int'($urandom_range(1, 3));
      end
      cyc++;
    end
    check({tag, "_left"}, 32'(exp_byte.size()), 32'd0);
    req_valid = '0; req_last = '0;
    @(negedge clk);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_no_timeout"}, 32'(tmo_seen), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [16];
    vt[0]  = '{4'b0010, 1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{4'b0010, 1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 4'b0010, 1'b1, 2'd1};
    vt[2]  = '{4'b0010, 1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h42, 4'b0010, 1'b1, 2'd1};
    vt[3]  = '{4'b0010, 1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h43, 4'b0010, 1'b1, 2'd1};
    vt[4]  = '{4'b0000, 1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
    vt[5]  = '{4'b0100, 2, 8'h61, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
    vt[6]  = '{4'b0100, 2, 8'h61, 1'b0, 1'b1, 1'b1, 8'h61, 4'b0100, 1'b1, 2'd2};
    vt[7]  = '{4'b0100, 2, 8'h62, 1'b1, 1'b0, 1'b1, 8'h62, 4'b0000, 1'b1, 2'd2};
    vt[8]  = '{4'b0100, 2, 8'h62, 1'b1, 1'b0, 1'b1, 8'h62, 4'b0000, 1'b1, 2'd2};
    vt[9]  = '{4'b0100, 2, 8'h62, 1'b1, 1'b1, 1'b1, 8'h62, 4'b0100, 1'b1, 2'd2};
    vt[10] = '{4'b0000, 2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
    vt[11] = '{4'b1001, 3, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
    vt[12] = '{4'b1001, 3, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 4'b1000, 1'b1, 2'd3};
    vt[13] = '{4'b0001, 0, 8'h5B, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3};
    vt[14] = '{4'b0001, 0, 8'h5B, 1'b1, 1'b1, 1'b1, 8'h5B, 4'b0001, 1'b1, 2'd0};
    vt[15] = '{4'b0000, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};

    do_reset();
    @(negedge clk);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_valid", 32'(to_uart_valid), 32'd0);
    check("rst_data", 32'(to_uart_data), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_error", 32'(to_uart_error), 32'd0);
    @(posedge clk);
    #1;

`ifndef UART_TX_ARB_TAG_EN
    // Cycle-accurate vectors: single message, backpressure, wrap and single-byte messages.
    for (int i = 0; i < 16; i++) begin
      req_valid = vt[i].v;
      req_last = '0;
      req_last[vt[i].src] = vt[i].l;
      for (int j = 0; j < NR; j++)
        req_data[8*j +: 8] = (j == vt[i].src) ? vt[i].d : (8'hF0 + 8'(j));
      to_uart_ready = vt[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(to_uart_valid), 32'(vt[i].ev));
      if (vt[i].ev) check($sformatf("vec%0d_data", i), 32'(to_uart_data), 32'(vt[i].ed));
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vt[i].er));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].eb));
      check($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(vt[i].eg));
      @(posedge clk);
      #1;
    end

    // Contention from reset: expected order 0,1,2,3,0 with one idle cycle between messages.
    do_reset();
    mc[0] = 2; mc[1] = 1; mc[2] = 1; mc[3] = 1;
    build_model(2, 2);
    check("cont_order", {exp_src[0][7:0], exp_src[2][7:0], exp_src[4][7:0], exp_src[6][7:0]},
          32'h00010203);
    run_stream(1'b1, 1'b0, "cont");

    // Random streams with mid-message source gaps (shorter than the timeout).
    do_reset();
    for (int i = 0; i < NR; i++) mc[i] = int'($urandom_range(1, 4));
    build_model(0, 5);
    run_stream(1'b0, 1'b1, "rand_bp");
    do_reset();
    for (int i = 0; i < NR; i++) mc[i] = int'($urandom_range(0, 4));
    build_model(0, 5);
    run_stream(1'b1, 1'b1, "rand_full");

    // Timeout: requester 0 sends one byte without last, then goes silent.
    do_reset();
    to_uart_ready = 1'b1;
    req_valid = 4'b1001;
    req_data = '0;
    req_data[7:0] = 8'h11;
    req_data[31:24] = 8'h77;
    req_last = 4'b1000;
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_first_data", 32'(to_uart_data), 32'h11);
    check("tmo_first_grant", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("tmo_pulse_k%0d", k), 32'(timeout_err), 32'(k == 8));
      if (k == 8) check("tmo_busy_drop", 32'(busy), 32'd0);
      if (k == 9) begin
        check("tmo_next_grant", 32'(grant_id), 32'd3);
        check("tmo_next_data", {31'h0, to_uart_valid} << 8 | 32'(to_uart_data), 32'h177);
      end
      @(posedge clk); #1;
    end

    // Reset mid-message: outputs clear asynchronously, then requester 0 wins first.
    do_reset();
    to_uart_ready = 1'b1;
    req_valid = 4'b0100;
    req_data = '0;
    req_last = '0;
    req_data[23:16] = 8'h21;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_data[23:16] = 8'h22;
    #2;
    check("rmid_before", {24'h0, to_uart_data}, 32'h22);
    reset = 1'b0;
    #1;
    check("rmid_valid", 32'(to_uart_valid), 32'd0);
    check("rmid_data", 32'(to_uart_data), 32'd0);
    check("rmid_ready", 32'(req_ready), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_grant", 32'(grant_id), 32'd0);
    repeat (2) @(posedge clk);
    req_valid = 4'b0101;
    req_data[7:0] = 8'h0A;
    req_last = 4'b0001;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rmid_after_grant", 32'(grant_id), 32'd0);
    check("rmid_after_data", 32'(to_uart_data), 32'h0A);
    @(posedge clk); #1;
`else
    // Tag build: requester 3's one-byte message goes out as 0x33 then 0x55.
    do_reset();
    to_uart_ready = 1'b1;
    req_valid = 4'b1000;
    req_data = '0;
    req_data[31:24] = 8'h55;
    req_last = 4'b1000;
    @(posedge clk); #1;
    @(negedge clk);
    check("tag_valid", 32'(to_uart_valid), 32'd1);
    check("tag_data", 32'(to_uart_data), 32'h33);
    check("tag_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("tag_byte", 32'(to_uart_data), 32'h55);
    check("tag_byte_ready", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("tag_busy_end", 32'(busy), 32'd0);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
